// File: rtl/mips32_pkg.sv
// Shared definitions for the pipe_MIPS32 issue-control logic.
package mips32_pkg;

  // Issue FSM states
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BR_WAIT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_HALTED  = 2'd3
  } issue_state_e;

  // Architectural register index width
  localparam int unsigned REG_IDX_W = 5;

  // Default producer-to-consumer issue distance (no forwarding)
  localparam int unsigned WB_DIST_DEFAULT = 3;

  // Opcodes decoded upstream into the id_* qualifiers
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_HLT   = 6'b111111;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;

endpackage

// File: rtl/mips_reg_scoreboard.sv
// Per-register countdown scoreboard: a register is busy while its counter is non-zero.
module mips_reg_scoreboard
  import mips32_pkg::*;
#(
  parameter int unsigned NREG    = 32,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned WB_DIST = WB_DIST_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ld_en,
  input  logic [REG_IDX_W-1:0] i_ld_idx,
  output logic [NREG-1:0]      o_busy_mask,
  output logic                 o_idle_next
);

  localparam logic [CNT_W-1:0] LD_VAL = CNT_W'(WB_DIST - 1);

  logic [CNT_W-1:0] r_cnt [NREG];

  // Load on issue (wins over decrement), otherwise count non-zero counters down
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NREG; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (i != 0 && i_ld_en && i_ld_idx == REG_IDX_W'(i))
          r_cnt[i] <= LD_VAL;
        else if (r_cnt[i] != '0)
          r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  // Busy flags straight from the counters; R0 is never busy
  always_comb begin
    o_busy_mask = '0;
    for (int unsigned i = 1; i < NREG; i++) o_busy_mask[i] = (r_cnt[i] != '0);
  end

  // True when every counter will be zero after this edge's update
  always_comb begin
    o_idle_next = !(i_ld_en && i_ld_idx != '0);
    for (int unsigned i = 0; i < NREG; i++)
      if (r_cnt[i] > CNT_W'(1)) o_idle_next = 1'b0;
  end

endmodule

// File: rtl/mips_issue_scoreboard.sv
// ID-stage issue control: RAW interlock, branch hold and halt drain.
module mips_issue_scoreboard
  import mips32_pkg::*;
#(
  parameter int unsigned WB_DIST = WB_DIST_DEFAULT,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned NREG    = 32
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_use_rs,
  input  logic                 id_use_rt,
  input  logic                 id_wr_en,
  input  logic                 id_is_branch,
  input  logic                 id_is_halt,
  input  logic                 br_resolve,
  input  logic                 br_taken,
  output logic                 issue,
  output logic                 stall,
  output logic                 flush,
  output logic                 halted,
  output logic [NREG-1:0]      busy_mask,
  output logic [31:0]          stall_count
);

  issue_state_e r_state, w_state_next;
  logic         r_flush, r_halted;
  logic [31:0]  r_stall_count;
  logic         w_hazard, w_issue, w_stall, w_idle_next;
  logic [NREG-1:0] w_busy_mask;

  mips_reg_scoreboard #(
    .NREG    (NREG),
    .CNT_W   (CNT_W),
    .WB_DIST (WB_DIST)
  ) u_sb (
    .i_clk       (clk1),
    .i_rst       (rst),
    .i_ld_en     (w_issue && id_wr_en),
    .i_ld_idx    (id_rd),
    .o_busy_mask (w_busy_mask),
    .o_idle_next (w_idle_next)
  );

  // RAW hazard check and issue/stall decision
  always_comb begin
    w_hazard = (id_use_rs && id_rs != '0 && w_busy_mask[id_rs]) ||
               (id_use_rt && id_rt != '0 && w_busy_mask[id_rt]);
    w_issue  = id_valid && r_state == ST_RUN && !w_hazard;
    w_stall  = id_valid && !w_issue;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_issue && id_is_branch)    w_state_next = ST_BR_WAIT;
        else if (w_issue && id_is_halt) w_state_next = ST_DRAIN;
      end
      ST_BR_WAIT: if (br_resolve)  w_state_next = ST_RUN;
      ST_DRAIN:   if (w_idle_next) w_state_next = ST_HALTED;
      ST_HALTED:  w_state_next = ST_HALTED;
      default:    w_state_next = ST_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk1) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  // Registered flush/halted flags and saturating stall counter
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_flush       <= 1'b0;
      r_halted      <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_flush  <= (r_state == ST_BR_WAIT) && br_resolve && br_taken;
      r_halted <= (w_state_next == ST_HALTED);
      if (w_stall && r_stall_count != '1) r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign issue       = w_issue;
  assign stall       = w_stall;
  assign flush       = r_flush;
  assign halted      = r_halted;
  assign busy_mask   = w_busy_mask;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_mips_issue_scoreboard.sv
// Self-checking bench for mips_issue_scoreboard: per-cycle expectations queued and compared.
module tb_mips_issue_scoreboard;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs, rt, rd;
    logic       use_rs, use_rt, wr, br, hlt, bres, btaken;
  } stim_t;

  logic        clk1 = 1'b0, rst = 1'b1;
  logic        id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_branch, id_is_halt;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        br_resolve, br_taken;
  logic        issue, stall, flush, halted;
  logic [31:0] busy_mask, stall_count;

  int unsigned errors = 0, checks = 0, exp_sc = 0;
  logic [3:0]  exq[$];
  logic [3:0]  got, want;

  mips_issue_scoreboard #(.WB_DIST(3), .CNT_W(2), .NREG(32)) dut (
    .clk1(clk1), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_is_branch(id_is_branch), .id_is_halt(id_is_halt), .br_resolve(br_resolve),
    .br_taken(br_taken), .issue(issue), .stall(stall), .flush(flush), .halted(halted),
    .busy_mask(busy_mask), .stall_count(stall_count)
  );

  always #5 clk1 = ~clk1;

  function automatic stim_t ins(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                                input logic urt, input logic [4:0] rd, input logic wr);
    stim_t s;
    s = '0;
    s.valid = 1'b1; s.rs = rs; s.use_rs = urs; s.rt = rt; s.use_rt = urt; s.rd = rd; s.wr = wr;
    return s;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Drive one cycle's inputs after the rising edge, return at the falling edge
  task automatic apply(input stim_t s, input logic r);
    @(posedge clk1); #1;
    rst = r;
    id_valid = s.valid; id_rs = s.rs; id_rt = s.rt; id_rd = s.rd;
    id_use_rs = s.use_rs; id_use_rt = s.use_rt; id_wr_en = s.wr;
    id_is_branch = s.br; id_is_halt = s.hlt; br_resolve = s.bres; br_taken = s.btaken;
    @(negedge clk1);
  endtask

  task automatic test_reset();
    apply(idle(), 1'b1);
    apply(idle(), 1'b1);
    apply(idle(), 1'b0);
    exp_sc = 0;
    exq.push_back(4'b0000);
    got = {issue, stall, flush, halted}; want = exq.pop_front();
    checks++;
    if (got !== want) begin errors++; $display("FAIL reset_flags got %b want %b", got, want); end
    checks++;
    if (busy_mask !== 32'h0) begin errors++; $display("FAIL reset_busy got %h want 0", busy_mask); end
    checks++;
    if (stall_count !== 32'd0) begin errors++; $display("FAIL reset_stall_count got %0d want 0", stall_count); end
  endtask

  // ADDI R10 then LW reading R10: two stall cycles
  task automatic test_raw();
    stim_t st[7];
    logic [3:0] ex[7];
    st = '{ins(1,1,0,0,10,1), ins(10,1,0,0,11,1), ins(10,1,0,0,11,1), ins(10,1,0,0,11,1),
           idle(), idle(), idle()};
    ex = '{4'b1000, 4'b0100, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 7; i++) begin
      exq.push_back(ex[i]);
      apply(st[i], 1'b0);
      got = {issue, stall, flush, halted}; want = exq.pop_front();
      if (want[2]) exp_sc++;
      checks++;
      if (got !== want) begin errors++; $display("FAIL raw step %0d got %b want %b", i, got, want); end
      if (i == 1) begin
        checks++;
        if (busy_mask[10] !== 1'b1) begin errors++; $display("FAIL raw_busy10 got %b want 1", busy_mask[10]); end
      end
    end
    checks++;
    if (busy_mask !== 32'h0) begin errors++; $display("FAIL raw_drained got %h want 0", busy_mask); end
    checks++;
    if (stall_count !== exp_sc) begin errors++; $display("FAIL raw_stall_count got %0d want %0d", stall_count, exp_sc); end
  endtask

  // Writes and reads of R0 never interlock
  task automatic test_r0();
    stim_t st[3];
    logic [3:0] ex[3];
    st = '{ins(1,1,0,0,0,1), ins(0,1,0,1,2,0), idle()};
    ex = '{4'b1000, 4'b1000, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      exq.push_back(ex[i]);
      apply(st[i], 1'b0);
      got = {issue, stall, flush, halted}; want = exq.pop_front();
      if (want[2]) exp_sc++;
      checks++;
      if (got !== want) begin errors++; $display("FAIL r0 step %0d got %b want %b", i, got, want); end
      checks++;
      if (busy_mask !== 32'h0) begin errors++; $display("FAIL r0_busy step %0d got %h want 0", i, busy_mask); end
    end
  endtask

  // rt dependence stalls; an unused rs field naming a busy register does not
  task automatic test_rt_hazard();
    stim_t st[6];
    logic [3:0] ex[6];
    st = '{ins(0,0,0,0,7,1), ins(7,0,0,0,8,0), ins(0,0,7,1,0,0), ins(0,0,7,1,0,0), idle(), idle()};
    ex = '{4'b1000, 4'b1000, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    for (int i = 0; i < 6; i++) begin
      exq.push_back(ex[i]);
      apply(st[i], 1'b0);
      got = {issue, stall, flush, halted}; want = exq.pop_front();
      if (want[2]) exp_sc++;
      checks++;
      if (got !== want) begin errors++; $display("FAIL rt_hazard step %0d got %b want %b", i, got, want); end
    end
  endtask

  // Reload of R5 while its old count is decrementing: reload wins
  task automatic test_load_wins();
    stim_t st[6];
    logic [3:0] ex[6];
    logic bx[6];
    st = '{ins(0,0,0,0,5,1), idle(), ins(0,0,0,0,5,1), idle(), idle(), idle()};
    ex = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    bx = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      exq.push_back(ex[i]);
      apply(st[i], 1'b0);
      got = {issue, stall, flush, halted}; want = exq.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL load_wins step %0d got %b want %b", i, got, want); end
      checks++;
      if (busy_mask[5] !== bx[i]) begin errors++; $display("FAIL load_wins_busy5 step %0d got %b want %b", i, busy_mask[5], bx[i]); end
    end
  endtask

  // Branch stalls on its source, blocks issue until resolve, flushes iff taken
  task automatic test_branch(input logic taken);
    stim_t st[12];
    logic [3:0] ex[12];
    stim_t b, r, g;
    b = ins(4,1,0,0,0,0); b.br = 1'b1;
    r = ins(1,1,2,1,6,1); r.bres = 1'b1; r.btaken = taken;
    g = ins(1,1,2,1,0,0); g.bres = 1'b1; g.btaken = 1'b1;
    st = '{ins(0,0,0,0,4,1), b, b, b, ins(1,1,2,1,6,1), idle(), r, ins(1,1,2,1,6,1),
           g, idle(), idle(), idle()};
    ex = '{4'b1000, 4'b0100, 4'b0100, 4'b1000, 4'b0100, 4'b0000, 4'b0100, 4'b1000,
           4'b1000, 4'b0000, 4'b0000, 4'b0000};
    ex[7][1] = taken;
    for (int i = 0; i < 12; i++) begin
      exq.push_back(ex[i]);
      apply(st[i], 1'b0);
      got = {issue, stall, flush, halted}; want = exq.pop_front();
      if (want[2]) exp_sc++;
      checks++;
      if (got !== want) begin errors++; $display("FAIL branch(taken=%0b) step %0d got %b want %b", taken, i, got, want); end
    end
    checks++;
    if (stall_count !== exp_sc) begin errors++; $display("FAIL branch_stall_count got %0d want %0d", stall_count, exp_sc); end
  endtask

  // Reset in BR_WAIT after stalls; then reset with a freshly loaded counter
  task automatic test_rst_mid();
    stim_t st[3];
    logic [3:0] ex[3];
    stim_t b;
    b = ins(1,1,0,0,0,0); b.br = 1'b1;
    st = '{ins(0,0,0,0,9,1), b, ins(9,1,0,0,0,0)};
    ex = '{4'b1000, 4'b1000, 4'b0100};
    for (int i = 0; i < 3; i++) begin
      exq.push_back(ex[i]);
      apply(st[i], 1'b0);
      got = {issue, stall, flush, halted}; want = exq.pop_front();
      if (want[2]) exp_sc++;
      checks++;
      if (got !== want) begin errors++; $display("FAIL rst_mid step %0d got %b want %b", i, got, want); end
    end
    apply(idle(), 1'b1);
    apply(idle(), 1'b0);
    exp_sc = 0;
    checks++;
    if (stall_count !== 32'd0) begin errors++; $display("FAIL rst_mid_stall_count got %0d want 0", stall_count); end
    checks++;
    if ({flush, halted} !== 2'b00) begin errors++; $display("FAIL rst_mid_flush_halted got %b want 00", {flush, halted}); end
    exq.push_back(4'b1000);
    apply(ins(9,1,0,0,14,1), 1'b0);
    got = {issue, stall, flush, halted}; want = exq.pop_front();
    checks++;
    if (got !== want) begin errors++; $display("FAIL rst_mid_run got %b want %b", got, want); end
    apply(idle(), 1'b1);
    apply(idle(), 1'b0);
    checks++;
    if (busy_mask !== 32'h0) begin errors++; $display("FAIL rst_mid_busy got %h want 0", busy_mask); end
  endtask

  // SUBI R3 then HLT: drain, raise halted, never issue; reset recovers
  task automatic test_halt();
    stim_t st[6];
    logic [3:0] ex[6];
    stim_t h;
    h = ins(0,0,0,0,0,0); h.hlt = 1'b1;
    st = '{ins(0,0,0,0,3,1), h, ins(1,1,0,0,2,1), ins(1,1,0,0,2,1), ins(1,1,0,0,2,1), idle()};
    ex = '{4'b1000, 4'b1000, 4'b0100, 4'b0101, 4'b0101, 4'b0001};
    for (int i = 0; i < 6; i++) begin
      exq.push_back(ex[i]);
      apply(st[i], 1'b0);
      got = {issue, stall, flush, halted}; want = exq.pop_front();
      if (want[2]) exp_sc++;
      checks++;
      if (got !== want) begin errors++; $display("FAIL halt step %0d got %b want %b", i, got, want); end
      if (i == 2) begin
        checks++;
        if (busy_mask[3] !== 1'b1) begin errors++; $display("FAIL halt_busy3 got %b want 1", busy_mask[3]); end
      end
    end
    checks++;
    if (stall_count !== exp_sc) begin errors++; $display("FAIL halt_stall_count got %0d want %0d", stall_count, exp_sc); end
    apply(idle(), 1'b1);
    exq.push_back(4'b1000);
    apply(ins(1,1,0,0,2,1), 1'b0);
    got = {issue, stall, flush, halted}; want = exq.pop_front();
    checks++;
    if (got !== want) begin errors++; $display("FAIL halt_reset_recover got %b want %b", got, want); end
  endtask

  initial begin
    apply(idle(), 1'b1);
    test_reset();
    test_raw();
    test_r0();
    test_rt_hazard();
    test_load_wins();
    test_branch(1'b1);
    test_branch(1'b0);
    test_rst_mid();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
